// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_arbiter
// Brief    : Round-robin front end for cache_ro: one lookup per request, miss
//            fill over an Avalon-MM read master, saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
module cache_fill_arbiter #(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int NREQ       = 2,
    parameter int CNT_W      = 32,
    localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*BIT_TOTAL-1:0] req_addr,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [SIZE_BLOCK-1:0]     rsp_data,
    input  logic                      rsp_ready,
    output logic                      c_en,
    output logic                      c_wrt,
    output logic [BIT_TOTAL-1:0]      c_addr,
    output logic [SIZE_BLOCK-1:0]     c_wdata,
    input  logic [SIZE_BLOCK-1:0]     c_rdata,
    input  logic                      c_success,
    output logic                      mem_read,
    output logic [BIT_TOTAL-1:0]      mem_addr,
    input  logic                      mem_waitrequest,
    input  logic [SIZE_BLOCK-1:0]     mem_readdata,
    input  logic                      mem_readdatavalid,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_CHECK    = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_FILL     = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IDW-1:0]        r_last;
    logic [IDW-1:0]        r_id;
    logic [BIT_TOTAL-1:0]  r_addr;
    logic [SIZE_BLOCK-1:0] r_data;
    logic [CNT_W-1:0]      r_hit_cnt;
    logic [CNT_W-1:0]      r_miss_cnt;
    logic                  w_grant_found;
    logic [IDW-1:0]        w_grant_id;
    logic [IDW:0]          w_scan;
    logic [BIT_TOTAL-1:0]  w_grant_addr;

    // Scan last+1 .. last+NREQ modulo NREQ; first pending requester wins.
    always_comb begin : p_grant
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_scan        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = {1'b0, r_last} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(NREQ)) begin
                w_scan = w_scan - (IDW+1)'(NREQ);
            end
            if (!w_grant_found && req_valid[w_scan[IDW-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_scan[IDW-1:0];
            end
        end
    end

    always_comb begin : p_addr_mux
        w_grant_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_id == IDW'(k)) begin
                w_grant_addr = req_addr[k*BIT_TOTAL +: BIT_TOTAL];
            end
        end
    end

    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin : p_fsm
        w_next    = r_state;
        req_ready = '0;
        c_en      = 1'b0;
        c_wrt     = 1'b0;
        mem_read  = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_found) begin
                    req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_id;
                    w_next    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                c_en   = 1'b1;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = c_success ? S_RESP : S_MEM_REQ;
            end
            S_MEM_REQ: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    w_next = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_readdatavalid) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                c_en   = 1'b1;
                c_wrt  = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : p_datapath
        if (rst) begin
            r_last     <= IDW'(NREQ - 1);
            r_id       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_last <= w_grant_id;
                        r_id   <= w_grant_id;
                        r_addr <= w_grant_addr;
                    end
                end
                S_CHECK: begin
                    if (c_success) begin
                        r_data <= c_rdata;
                        if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        end
                    end else if (r_miss_cnt != '1) begin
                        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_readdatavalid) begin
                        r_data <= mem_readdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data outputs are forced to zero outside the states that own them.
    assign c_addr   = c_en      ? r_addr : '0;
    assign c_wdata  = c_wrt     ? r_data : '0;
    assign mem_addr = mem_read  ? r_addr : '0;
    assign rsp_id   = rsp_valid ? r_id   : '0;
    assign rsp_data = rsp_valid ? r_data : '0;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_arbiter
// Brief    : Bench for cache_fill_arbiter with cache, Avalon memory and
//            requester models; expected results come from a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_cache_fill_arbiter;

    localparam int SB    = 32;
    localparam int BT    = 24;
    localparam int NREQ  = 2;
    localparam int CNT_W = 4;
    localparam int IDW   = 1;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BT-1:0]   req_addr;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [SB-1:0]        rsp_data;
    logic                 rsp_ready;
    logic                 c_en;
    logic                 c_wrt;
    logic [BT-1:0]        c_addr;
    logic [SB-1:0]        c_wdata;
    logic [SB-1:0]        c_rdata;
    logic                 c_success;
    logic                 mem_read;
    logic [BT-1:0]        mem_addr;
    logic                 mem_waitrequest;
    logic [SB-1:0]        mem_readdata;
    logic                 mem_readdatavalid;
    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     miss_cnt;

    cache_fill_arbiter #(
        .SIZE_BLOCK (SB),
        .BIT_TOTAL  (BT),
        .NREQ       (NREQ),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .rsp_valid         (rsp_valid),
        .rsp_id            (rsp_id),
        .rsp_data          (rsp_data),
        .rsp_ready         (rsp_ready),
        .c_en              (c_en),
        .c_wrt             (c_wrt),
        .c_addr            (c_addr),
        .c_wdata           (c_wdata),
        .c_rdata           (c_rdata),
        .c_success         (c_success),
        .mem_read          (mem_read),
        .mem_addr          (mem_addr),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Environment and reference state
    logic [SB-1:0]   cache_m [int];
    bit [NREQ-1:0]   pend_v;
    logic [BT-1:0]   pend_a [NREQ];
    int              last, exp_hit, exp_miss, last_grant;
    int              acc_count, fill_count, stall_cnt;
    logic [BT-1:0]   acc_addr, fill_addr, mem_a;
    logic [SB-1:0]   fill_data;
    bit              mem_busy;
    int              mem_cnt, force_wait, force_lat, grant_clear;
    bit              rand_reqs, refill_all, busy_txn;
    logic            p_cen, p_cwrt, p_mread, p_wait, p_rst;
    logic [BT-1:0]   p_caddr, p_maddr;
    logic [SB-1:0]   p_cwdata;

    function automatic logic [SB-1:0] mem_f(input logic [BT-1:0] a);
        if (a == 24'h000003) return 32'hDEADBEEF;
        return ({8'h00, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [BT-1:0] pick_addr();
        return 24'h000010 + BT'($urandom_range(0, 7));
    endfunction

    function automatic int exp_grant();
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (pend_v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = pend_v[i];
            req_addr[i*BT +: BT]  = pend_a[i];
        end
    endtask

    task automatic post(input int idx, input logic [BT-1:0] a);
        pend_v[idx] = 1'b1;
        pend_a[idx] = a;
        drive_reqs();
        #1;
    endtask

    // One clock: models react to what the DUT presented before the edge.
    task automatic step();
        p_cen = c_en;  p_cwrt = c_wrt;  p_caddr = c_addr;  p_cwdata = c_wdata;
        p_mread = mem_read;  p_maddr = mem_addr;  p_wait = mem_waitrequest;  p_rst = rst;
        @(posedge clk);
        #1;
        c_success = 1'($urandom);
        c_rdata   = $urandom;
        if (p_cen && !p_cwrt) begin
            c_success = (cache_m.exists(int'(p_caddr)) != 0);
            if (c_success) c_rdata = cache_m[int'(p_caddr)];
        end
        if (p_cen && p_cwrt) begin
            cache_m[int'(p_caddr)] = p_cwdata;
            fill_count++;
            fill_addr = p_caddr;
            fill_data = p_cwdata;
        end
        mem_readdatavalid = 1'b0;
        mem_readdata      = $urandom;
        if (p_mread && !p_wait) begin
            acc_count++;
            acc_addr = p_maddr;
            mem_a    = p_maddr;
            mem_busy = 1'b1;
            mem_cnt  = (force_lat > 0) ? force_lat : int'($urandom_range(1, 3));
            force_lat = 0;
        end
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_busy          = 1'b0;
                mem_readdatavalid = 1'b1;
                mem_readdata      = mem_f(mem_a);
            end
        end
        if (p_mread && p_wait) begin
            stall_cnt++;
            if (force_wait > 0) force_wait--;
        end
        mem_waitrequest = (force_wait > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
        if (grant_clear >= 0) begin
            pend_v[grant_clear] = 1'b0;
            grant_clear = -1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pend_v[i] && (refill_all || (rand_reqs && $urandom_range(0, 1) == 1))) begin
                pend_v[i] = 1'b1;
                pend_a[i] = pick_addr();
            end
        end
        drive_reqs();
        #1;
        if (p_mread && p_wait && !p_rst) begin
            chk("mem_read_held", 64'(mem_read), 64'd1);
            chk("mem_addr_held", 64'(mem_addr), 64'(p_maddr));
        end
        if (busy_txn) chk("req_ready_only_idle", 64'(req_ready), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"},  64'({rsp_valid, req_ready, c_en, c_wrt, mem_read, rsp_id}), 64'd0);
        chk({tag, "_cnt"},  64'({hit_cnt, miss_cnt}), 64'd0);
        chk({tag, "_addr"}, 64'({c_addr, mem_addr}), 64'd0);
        chk({tag, "_data"}, {c_wdata, rsp_data}, 64'd0);
    endtask

    // Full transaction: grant, lookup/fill, response held for `hold` cycles.
    task automatic serve_one(input int hold);
        int            n, g, lat, a0, f0;
        logic [BT-1:0] addr;
        bit            hit;
        logic [IDW-1:0] sid;
        logic [SB-1:0] sdata;
        n = 0;
        while (req_ready == '0 && n < 40) begin step(); n++; end
        chk("grant_seen", 64'(req_ready != '0), 64'd1);
        if (req_ready == '0) return;
        g = exp_grant();
        chk("grant_onehot", 64'(req_ready), 64'(1 << g));
        last_grant = g;
        addr = pend_a[g];
        hit  = (cache_m.exists(int'(addr)) != 0);
        last = g;
        a0 = acc_count;
        f0 = fill_count;
        grant_clear = g;
        busy_txn = 1'b1;
        step();
        lat = 1;
        while (!rsp_valid && lat < 100) begin step(); lat++; end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_data", 64'(rsp_data), 64'(mem_f(addr)));
        if (hit) begin
            chk("hit_latency", 64'(lat), 64'd3);
            chk("hit_no_mem_read", 64'(acc_count - a0), 64'd0);
            chk("hit_no_fill", 64'(fill_count - f0), 64'd0);
            if (exp_hit < CMAX) exp_hit++;
        end else begin
            chk("miss_mem_reads", 64'(acc_count - a0), 64'd1);
            chk("miss_mem_addr", 64'(acc_addr), 64'(addr));
            chk("miss_fills", 64'(fill_count - f0), 64'd1);
            chk("fill_addr", 64'(fill_addr), 64'(addr));
            chk("fill_data", 64'(fill_data), 64'(mem_f(addr)));
            if (exp_miss < CMAX) exp_miss++;
        end
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        sid   = rsp_id;
        sdata = rsp_data;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_hold_id", 64'(rsp_id), 64'(sid));
            chk("rsp_hold_data", 64'(rsp_data), 64'(sdata));
        end
        busy_txn  = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_single", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int n, a0, f0, s0, guard;
        bit seen;
        int grants[4];
        rst = 1'b1;  req_valid = '0;  req_addr = '0;  rsp_ready = 1'b0;
        c_rdata = '0;  c_success = 1'b0;  mem_waitrequest = 1'b0;
        mem_readdata = '0;  mem_readdatavalid = 1'b0;
        pend_v = '0;
        for (int i = 0; i < NREQ; i++) pend_a[i] = '0;
        last = NREQ - 1;  exp_hit = 0;  exp_miss = 0;  last_grant = -1;
        acc_count = 0;  fill_count = 0;  stall_cnt = 0;  mem_busy = 1'b0;  mem_cnt = 0;
        force_wait = 0;  force_lat = 0;  grant_clear = -1;
        rand_reqs = 1'b0;  refill_all = 1'b0;  busy_txn = 1'b0;
        acc_addr = '0;  fill_addr = '0;  fill_data = '0;  mem_a = '0;

        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;

        // Cold miss on 0x3, memory answers two cycles after acceptance
        force_lat = 2;
        post(0, 24'h000003);
        serve_one(0);
        chk("t1_fill_data", 64'(fill_data), 64'h0000_0000_DEAD_BEEF);
        chk("t1_miss_cnt", 64'(miss_cnt), 64'd1);

        // Same address again hits
        post(0, 24'h000003);
        serve_one(1);
        chk("t2_hit_cnt", 64'(hit_cnt), 64'd1);

        // Reset while waiting on memory; the late read data must be ignored
        force_lat = 8;
        post(0, 24'h000ABC);
        n = 0;
        while (req_ready == '0 && n < 10) begin step(); n++; end
        chk("t5_grant", 64'(req_ready), 64'd1);
        grant_clear = 0;
        a0 = acc_count;
        f0 = fill_count;
        n = 0;
        while (acc_count == a0 && n < 30) begin step(); n++; end
        chk("t5_mem_accept", 64'(acc_count - a0), 64'd1);
        step();
        rst = 1'b1;
        step();
        check_reset("t5_reset");
        step();
        rst = 1'b0;
        last = NREQ - 1;  exp_hit = 0;  exp_miss = 0;
        seen = 1'b0;
        repeat (12) begin
            step();
            if (rsp_valid || c_en || mem_read) seen = 1'b1;
        end
        chk("t5_quiet_after_reset", 64'(seen), 64'd0);
        chk("t5_no_fill", 64'(fill_count - f0), 64'd0);
        chk("t5_counters", 64'({hit_cnt, miss_cnt}), 64'd0);
        post(1, pick_addr());
        serve_one(0);

        // Both requesters always pending: strict alternation from requester 0
        refill_all = 1'b1;
        post(0, pick_addr());
        post(1, pick_addr());
        for (int t = 0; t < 4; t++) begin
            serve_one(0);
            grants[t] = last_grant;
        end
        refill_all = 1'b0;
        chk("t3_grant_order", 64'({grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]}),
            64'b00_01_00_01);
        guard = 0;
        while (pend_v != '0 && guard < 8) begin serve_one(0); guard++; end

        // Stalled Avalon request and back-pressured response
        s0 = stall_cnt;
        force_wait = 5;
        post(1, 24'h000777);
        serve_one(4);
        chk("t4_stall_cycles", 64'((stall_cnt - s0) >= 5), 64'd1);

        // Randomized traffic from both requesters
        rand_reqs = 1'b1;
        repeat (24) serve_one(int'($urandom_range(0, 2)));
        rand_reqs = 1'b0;
        guard = 0;
        while (pend_v != '0 && guard < 8) begin serve_one(0); guard++; end

        // Saturate the hit counter, then one more hit
        guard = 0;
        while (exp_hit < CMAX && guard < 20) begin
            post(0, 24'h000003);
            serve_one(0);
            guard++;
        end
        post(0, 24'h000003);
        serve_one(0);
        chk("t6_hit_saturated", 64'(hit_cnt), 64'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
